// File: rtl/fighter_pkg.sv
// fighter_pkg: shared state encodings, screen constants and direction codes for fighter blocks
package fighter_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK  = 3'd1,
    S_AIR   = 3'd2,
    S_KNOCK = 3'd3,
    S_LAND  = 3'd4
  } state_t;
  localparam int SCREEN_GROUND_X = 40;
  localparam int SCREEN_GROUND_Y = 400;
  localparam int SCREEN_MIN_X    = 40;
  localparam int SCREEN_MAX_X    = 600;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/player_motion_if.sv
// player_motion_if: command inputs and position/status outputs of the player motion block
interface player_motion_if #(parameter int POS_WIDTH = 10);
  logic                 SCEN, move_enable, move_left, move_right, jump, hit, hit_from_right;
  logic [POS_WIDTH-1:0] opponent_x, pos_x, pos_y;
  logic                 facing_right, move_active, jump_active, land_pulse;
  logic [2:0]           state;
  modport master (
    output SCEN, move_enable, move_left, move_right, jump, hit, hit_from_right, opponent_x,
    input  pos_x, pos_y, facing_right, state, move_active, jump_active, land_pulse
  );
  modport slave (
    input  SCEN, move_enable, move_left, move_right, jump, hit, hit_from_right, opponent_x,
    output pos_x, pos_y, facing_right, state, move_active, jump_active, land_pulse
  );
endinterface

// File: rtl/jump_arc.sv
// jump_arc: height/vertical-velocity integrator with landing detection
module jump_arc #(
  parameter int POS_WIDTH = 10,
  parameter int VEL_WIDTH = 6,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic                 i_step,
  output logic [POS_WIDTH-1:0] o_h,
  output logic                 o_landed,
  output logic                 o_moving
);
  logic signed [VEL_WIDTH-1:0] r_vy;
  logic [POS_WIDTH-1:0]        r_h;
  logic signed [POS_WIDTH+1:0] w_hn;
  assign w_hn     = $signed({2'b00, r_h}) + (POS_WIDTH+2)'(r_vy);
  assign o_landed = w_hn[POS_WIDTH+1] || w_hn == '0;
  assign o_moving = i_step && (o_landed ? r_h != '0 : w_hn[POS_WIDTH-1:0] != r_h);
  assign o_h      = r_h;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_h  <= '0;
      r_vy <= '0;
    end else if (i_start) begin
      r_h  <= '0;
      r_vy <= VEL_WIDTH'(JUMP_V0);
    end else if (i_step) begin
      r_h  <= o_landed ? '0 : w_hn[POS_WIDTH-1:0];
      r_vy <= o_landed ? '0 : r_vy - VEL_WIDTH'(GRAVITY);
    end
endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame fighter movement FSM (walk, jump arc, knockback, landing recovery)
module player_motion
  import fighter_pkg::*;
#(
  parameter int POS_WIDTH    = 10,
  parameter int VEL_WIDTH    = 6,
  parameter int GROUND_X     = SCREEN_GROUND_X,
  parameter int GROUND_Y     = SCREEN_GROUND_Y,
  parameter int MIN_X        = SCREEN_MIN_X,
  parameter int MAX_X        = SCREEN_MAX_X,
  parameter int WALK_SPEED   = 2,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1,
  parameter int KNOCK_SPEED  = 4,
  parameter int KNOCK_FRAMES = 8,
  parameter int LAND_FRAMES  = 2,
  parameter int MIN_SEP      = 32
) (
  input logic             clk,
  input logic             reset_n,
  player_motion_if.slave  bus
);
  localparam int XW = POS_WIDTH + 2;
  localparam logic signed [XW-1:0] L_MIN = XW'(MIN_X), L_MAX = XW'(MAX_X), L_SEP = XW'(MIN_SEP);
  localparam logic signed [XW-1:0] L_WALK = XW'(WALK_SPEED), L_KNOCK = XW'(KNOCK_SPEED);
  state_t                      r_state;
  logic [POS_WIDTH-1:0]        r_pos_x, w_h, w_x_cl, w_x_next;
  logic signed [VEL_WIDTH-1:0] r_vx;
  logic [7:0]                  r_cnt;
  logic                        r_facing, r_move, r_land, r_kdir;
  logic                        w_ground, w_go_air, w_walk, w_kdir, w_step, w_landed, w_y_moving;
  logic                        w_wall, w_block;
  logic signed [XW-1:0]        w_delta, w_xc, w_dist;
  assign w_ground = r_state == S_IDLE || r_state == S_WALK;
  assign w_go_air = w_ground && !bus.hit && bus.jump && bus.move_enable;
  assign w_walk   = w_ground && !bus.hit && !bus.jump && bus.move_enable && (bus.move_left ^ bus.move_right);
  assign w_kdir   = bus.hit ? (bus.hit_from_right ? DIR_LEFT : DIR_RIGHT) : r_kdir;
  assign w_step   = bus.SCEN && r_state == S_AIR;
  // Clamp before the separation check so a wall-limited step is judged at its real landing x
  always_comb begin
    w_delta  = r_state == S_AIR ? XW'(r_vx)
             : r_state == S_KNOCK ? (w_kdir == DIR_RIGHT ? L_KNOCK : -L_KNOCK)
             : w_walk ? (bus.move_right ? L_WALK : -L_WALK) : '0;
    w_xc     = $signed({2'b00, r_pos_x}) + w_delta;
    w_wall   = w_xc < L_MIN || w_xc > L_MAX;
    w_x_cl   = w_xc < L_MIN ? POS_WIDTH'(MIN_X) : w_xc > L_MAX ? POS_WIDTH'(MAX_X) : w_xc[POS_WIDTH-1:0];
    w_dist   = $signed({2'b00, w_x_cl}) - $signed({2'b00, bus.opponent_x});
    w_block  = w_walk && (bus.move_right ? bus.opponent_x > r_pos_x : bus.opponent_x < r_pos_x)
               && w_dist < L_SEP && w_dist > -L_SEP;
    w_x_next = w_block ? r_pos_x : w_x_cl;
  end
  jump_arc #(
    .POS_WIDTH(POS_WIDTH), .VEL_WIDTH(VEL_WIDTH), .JUMP_V0(JUMP_V0), .GRAVITY(GRAVITY)
  ) u_arc (
    .clk(clk), .reset_n(reset_n), .i_start(bus.SCEN && w_go_air), .i_step(w_step),
    .o_h(w_h), .o_landed(w_landed), .o_moving(w_y_moving)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pos_x  <= POS_WIDTH'(GROUND_X);
      r_vx     <= '0;
      r_cnt    <= '0;
      r_facing <= 1'b1;
      r_move   <= 1'b0;
      r_land   <= 1'b0;
      r_kdir   <= DIR_LEFT;
    end else begin
      r_land <= w_step && w_landed;
      if (bus.SCEN) begin
        r_pos_x <= w_x_next;
        r_move  <= w_x_next != r_pos_x || w_y_moving;
        if (r_state != S_AIR && r_state != S_KNOCK && bus.opponent_x != r_pos_x)
          r_facing <= bus.opponent_x > r_pos_x;
        case (r_state)
          S_IDLE, S_WALK: begin
            r_cnt   <= '0;
            r_kdir  <= w_kdir;
            r_vx    <= !(bus.move_left ^ bus.move_right) ? '0
                     : bus.move_right ? VEL_WIDTH'(WALK_SPEED) : -VEL_WIDTH'(WALK_SPEED);
            r_state <= bus.hit ? S_KNOCK : w_go_air ? S_AIR : w_walk ? S_WALK : S_IDLE;
          end
          S_AIR: begin
            r_cnt <= '0;
            r_vx  <= w_landed ? '0
                   : bus.hit ? (w_kdir == DIR_RIGHT ? VEL_WIDTH'(KNOCK_SPEED) : -VEL_WIDTH'(KNOCK_SPEED))
                   : w_wall ? '0 : r_vx;
            if (w_landed) r_state <= S_LAND;
          end
          S_KNOCK: begin
            r_kdir <= w_kdir;
            r_cnt  <= bus.hit || r_cnt == 8'(KNOCK_FRAMES-1) ? '0 : r_cnt + 8'd1;
            if (!bus.hit && r_cnt == 8'(KNOCK_FRAMES-1)) r_state <= S_IDLE;
          end
          default: begin
            r_kdir  <= w_kdir;
            r_cnt   <= bus.hit || r_cnt == 8'(LAND_FRAMES-1) ? '0 : r_cnt + 8'd1;
            r_state <= bus.hit ? S_KNOCK : r_cnt == 8'(LAND_FRAMES-1) ? S_IDLE : S_LAND;
          end
        endcase
      end
    end
  assign bus.pos_x        = r_pos_x;
  assign bus.pos_y        = POS_WIDTH'(GROUND_Y) - w_h;
  assign bus.facing_right = r_facing;
  assign bus.state        = r_state;
  assign bus.move_active  = r_move;
  assign bus.jump_active  = r_state == S_AIR;
  assign bus.land_pulse   = r_land;
endmodule
